vmicro16_uart_rx_apb: RTL and testbench

- APB3 slave UART receiver on the shared peripheral bus, downstream of the APB interconnect, alongside the GPIO and UART-TX slaves.
- Oversamples the serial rx line, deframes 8N1 bytes, and buffers them in a small FIFO.
- Cores read received bytes, status and control through zero-wait-state APB accesses.

---
 rtl/vmicro16_uart_pkg.sv | 31 +++
 rtl/vmicro16_fifo_sync.sv | 64 ++++++
 rtl/vmicro16_uart_rx_apb.sv | 240 ++++++++++++++++++++++++
 tb/tb_vmicro16_uart_rx_apb.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmicro16_uart_pkg.sv
// Shared definitions for the vmicro16 UART peripherals: register offsets,
// STATUS/CTRL bit positions and the receiver state encoding.
package vmicro16_uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  localparam logic [1:0] UART_RX_DATA   = 2'd0;
  localparam logic [1:0] UART_RX_STATUS = 2'd1;
  localparam logic [1:0] UART_RX_CTRL   = 2'd2;

  localparam int unsigned ST_NOT_EMPTY  = 0;
  localparam int unsigned ST_FULL       = 1;
  localparam int unsigned ST_OVERRUN    = 2;
  localparam int unsigned ST_FRAME_ERR  = 3;
  localparam int unsigned ST_PARITY_ERR = 4;
  localparam int unsigned ST_COUNT_LSB  = 8;
  localparam int unsigned ST_COUNT_W    = 4;

  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

endpackage

// File: rtl/vmicro16_fifo_sync.sv
// Single-clock circular FIFO with occupancy count; push is accepted at full
// only when a pop happens in the same cycle.
module vmicro16_fifo_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CNTW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNTW-1:0]  count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_c, do_pop_c;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_comb begin
    do_pop_c  = pop && (count_q != '0);
    do_push_c = push && ((count_q != CNTW'(DEPTH)) || do_pop_c);
    wr_ptr_d  = do_push_c ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = do_pop_c ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q;
    if (do_push_c && !do_pop_c) begin
      count_d = count_q + CNTW'(1);
    end else if (do_pop_c && !do_push_c) begin
      count_d = count_q - CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CNTW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/vmicro16_uart_rx_apb.sv
// APB3 UART receiver: oversampled 8N1 deframer feeding a receive FIFO.
// Define VMICRO16_UART_RX_PARITY_EN to add an even-parity bit and STATUS[4].
module vmicro16_uart_rx_apb
  import vmicro16_uart_pkg::*;
#(
  parameter int unsigned BUS_WIDTH    = 16,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] S_PADDR,
  input  logic                 S_PWRITE,
  input  logic                 S_PSELx,
  input  logic                 S_PENABLE,
  input  logic [BUS_WIDTH-1:0] S_PWDATA,
  output logic [BUS_WIDTH-1:0] S_PRDATA,
  output logic                 S_PREADY,
  input  logic                 rx_wire,
  output logic                 rx_irq
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);

  logic                   sync1_q, sync2_q, prev_q;
  rx_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [UART_BYTE_W-1:0] shift_q, shift_d;
  logic                   enable_q, enable_d, irq_en_q, irq_en_d;
  logic                   overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic                   parity_err_c;
  logic                   access_c, status_wr_c, ctrl_wr_c;
  logic [1:0]             addr_c;
  logic                   fifo_push_c, fifo_pop_c, frame_set_c;
  logic [UART_BYTE_W-1:0] fifo_head;
  logic                   fifo_full, fifo_empty;
  logic [CNTW-1:0]        fifo_count;
  logic [15:0]            rdata_c;
  logic                   unused_c;

  assign addr_c      = S_PADDR[1:0];
  assign access_c    = S_PSELx && S_PENABLE;
  assign status_wr_c = access_c && S_PWRITE && (addr_c == UART_RX_STATUS);
  assign ctrl_wr_c   = access_c && S_PWRITE && (addr_c == UART_RX_CTRL);
  assign fifo_pop_c  = access_c && !S_PWRITE && (addr_c == UART_RX_DATA);
  assign unused_c    = ^{S_PADDR, S_PWDATA};

`ifdef VMICRO16_UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d, parity_err_q, parity_err_d, parity_set_c;
`endif

  always_comb begin
    enable_d = enable_q;
    irq_en_d = irq_en_q;
    if (ctrl_wr_c) begin
      enable_d = S_PWDATA[CTRL_ENABLE];
      irq_en_d = S_PWDATA[CTRL_IRQ_EN];
    end
  end

  // Receiver FSM; a CTRL write clearing enable aborts the frame in the same cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    fifo_push_c = 1'b0;
    frame_set_c = 1'b0;
`ifdef VMICRO16_UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_set_c = 1'b0;
`endif
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d = {sync2_q, shift_q[UART_BYTE_W-1:1]};
          bit_d   = bit_q + 3'd1;
`ifdef VMICRO16_UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_d = RX_PARITY;
`else
          if (bit_q == 3'd7) state_d = RX_STOP;
`endif
        end
      end
`ifdef VMICRO16_UART_RX_PARITY_EN
      RX_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          par_bad_d    = sync2_q ^ (^shift_q);
          parity_set_c = par_bad_d;
          state_d      = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          if (sync2_q) begin
`ifdef VMICRO16_UART_RX_PARITY_EN
            fifo_push_c = !par_bad_q;
`else
            fifo_push_c = 1'b1;
`endif
            state_d = RX_IDLE;
          end else begin
            frame_set_c = 1'b1;
            state_d     = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        cnt_d = '0;
        if (sync2_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
    if (!enable_d) begin
      state_d     = RX_IDLE;
      fifo_push_c = 1'b0;
      frame_set_c = 1'b0;
`ifdef VMICRO16_UART_RX_PARITY_EN
      parity_set_c = 1'b0;
`endif
    end
  end

  // Sticky error flags: write-1-to-clear, a new set in the same cycle wins
  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (status_wr_c && S_PWDATA[ST_OVERRUN])   overrun_d   = 1'b0;
    if (status_wr_c && S_PWDATA[ST_FRAME_ERR]) frame_err_d = 1'b0;
    if (fifo_push_c && fifo_full && !fifo_pop_c) overrun_d = 1'b1;
    if (frame_set_c) frame_err_d = 1'b1;
  end

`ifdef VMICRO16_UART_RX_PARITY_EN
  always_comb begin
    parity_err_d = parity_err_q;
    if (status_wr_c && S_PWDATA[ST_PARITY_ERR]) parity_err_d = 1'b0;
    if (parity_set_c) parity_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err_c = parity_err_q;
`else
  assign parity_err_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      enable_q    <= 1'b1;
      irq_en_q    <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= rx_wire;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      enable_q    <= enable_d;
      irq_en_q    <= irq_en_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  vmicro16_fifo_sync #(
    .WIDTH(UART_BYTE_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(reset),
    .push (fifo_push_c),
    .wdata(shift_q),
    .pop  (fifo_pop_c),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_comb begin
    rdata_c = 16'h0000;
    case (addr_c)
      UART_RX_DATA: rdata_c = {8'h00, fifo_empty ? 8'h00 : fifo_head};
      UART_RX_STATUS: begin
        rdata_c[ST_NOT_EMPTY]  = !fifo_empty;
        rdata_c[ST_FULL]       = fifo_full;
        rdata_c[ST_OVERRUN]    = overrun_q;
        rdata_c[ST_FRAME_ERR]  = frame_err_q;
        rdata_c[ST_PARITY_ERR] = parity_err_c;
        rdata_c[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
      end
      UART_RX_CTRL: begin
        rdata_c[CTRL_ENABLE] = enable_q;
        rdata_c[CTRL_IRQ_EN] = irq_en_q;
      end
      default: rdata_c = 16'h0000;
    endcase
  end

  // Bus outputs are held at zero while reset is asserted
  assign S_PRDATA = (reset && S_PSELx) ? BUS_WIDTH'(rdata_c) : '0;
  assign S_PREADY = reset && access_c;
  assign rx_irq   = irq_en_q && !fifo_empty;

endmodule

// File: tb/tb_vmicro16_uart_rx_apb.sv
// Self-checking bench for vmicro16_uart_rx_apb against a queue-based model
// of the receive path (CLKS_PER_BIT=16, FIFO_DEPTH=8).
module tb_vmicro16_uart_rx_apb;

  localparam int CPB      = 16;
  localparam int DEPTH    = 8;
  localparam int IDLE_GAP = 4;
`ifdef VMICRO16_UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Edge (counted from the first posedge of the start bit) at which the stop
  // sample commits: 2-flop sync + edge register + half bit + remaining bits.
  localparam int PUSH_EDGE = 3 + CPB / 2 + (FRAME_BITS - 1) * CPB;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready, rx, rx_irq;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  logic       m_ovr, m_frame, m_par;
`ifdef VMICRO16_UART_RX_PARITY_EN
  logic       par_flip = 1'b0;
`endif

  always #5 clk = ~clk;

  vmicro16_uart_rx_apb #(
    .BUS_WIDTH(16),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .S_PADDR  (paddr),
    .S_PWRITE (pwrite),
    .S_PSELx  (psel),
    .S_PENABLE(penable),
    .S_PWDATA (pwdata),
    .S_PRDATA (prdata),
    .S_PREADY (pready),
    .rx_wire  (rx),
    .rx_irq   (rx_irq)
  );

  function automatic logic [15:0] exp_status();
    logic [15:0] s;
    s        = 16'h0000;
    s[0]     = (q.size() != 0);
    s[1]     = (q.size() == DEPTH);
    s[2]     = m_ovr;
    s[3]     = m_frame;
    s[4]     = m_par;
    s[11:8]  = 4'(q.size());
    return s;
  endfunction

  function automatic logic [15:0] exp_data_pop();
    if (q.size() == 0) return 16'h0000;
    return {8'h00, q.pop_front()};
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovr = 1'b0; m_frame = 1'b0; m_par = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_b);
    logic par_ok;
    par_ok = 1'b1;
`ifdef VMICRO16_UART_RX_PARITY_EN
    par_ok = !par_flip;
    if (!par_ok) m_par = 1'b1;
`endif
    if (!stop_b) m_frame = 1'b1;
    if (stop_b && par_ok) begin
      if (q.size() >= DEPTH) m_ovr = 1'b1;
      else q.push_back(b);
    end
  endtask

  task automatic apb_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    paddr = 16'(a); pwrite = 1'b1; psel = 1'b1; penable = 1'b0; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [1:0] a, output logic [15:0] d, output logic rdy);
    @(negedge clk);
    paddr = 16'(a); pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1;
    d = prdata; rdy = pready;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  // Serial frame, each bit held for CPB clocks starting on a negedge
  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef VMICRO16_UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop_b;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (IDLE_GAP) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] d; logic r;
    reset = 1'b0; rx = 1'b1; pwdata = 16'h0; pwrite = 1'b0;
    paddr = 16'h2; psel = 1'b1; penable = 1'b1;
    #3;
    vectors++;
    if (prdata !== 16'h0000 || pready !== 1'b0 || rx_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got prdata=%h pready=%b irq=%b want 0/0/0", prdata, pready, rx_irq);
    end
    psel = 1'b0; penable = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    apb_read(2'd1, d, r);
    vectors++;
    if (d !== exp_status()) begin miscompares++; $display("FAIL reset_status: got %h want %h", d, exp_status()); end
    apb_read(2'd2, d, r);
    vectors++;
    if (d !== 16'h0001) begin miscompares++; $display("FAIL reset_ctrl: got %h want 0001", d); end
  endtask

  task automatic test_single_a5();
    logic [15:0] d, e; logic r;
    send_frame(8'hA5, 1'b1); model_frame(8'hA5, 1'b1);
    apb_read(2'd1, d, r);
    vectors++;
    if (d !== 16'h0101 || r !== 1'b1) begin miscompares++; $display("FAIL a5_status: got %h rdy=%b want 0101 rdy=1", d, r); end
    apb_write(2'd0, 16'h00FF);
    e = exp_data_pop();
    apb_read(2'd0, d, r);
    vectors++;
    if (d !== e || e !== 16'h00A5 || r !== 1'b1) begin miscompares++; $display("FAIL a5_data: got %h rdy=%b want %h rdy=1", d, r, e); end
    apb_read(2'd1, d, r);
    vectors++;
    if (d !== exp_status() || r !== 1'b1) begin miscompares++; $display("FAIL a5_status_after: got %h want %h", d, exp_status()); end
    apb_read(2'd3, d, r);
    vectors++;
    if (d !== 16'h0000 || r !== 1'b1) begin miscompares++; $display("FAIL reg3_read: got %h want 0000", d); end
  endtask

  task automatic test_overrun();
    logic [15:0] d, e; logic r;
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b1); model_frame(8'(i), 1'b1);
    end
    apb_read(2'd1, d, r);
    vectors++;
    if (d !== exp_status() || d !== 16'h0807) begin miscompares++; $display("FAIL ovr_status: got %h want %h", d, exp_status()); end
    for (int i = 0; i < 9; i++) begin
      e = exp_data_pop();
      apb_read(2'd0, d, r);
      vectors++;
      if (d !== e) begin miscompares++; $display("FAIL ovr_data%0d: got %h want %h", i, d, e); end
    end
    apb_write(2'd1, 16'h0004); m_ovr = 1'b0;
    apb_read(2'd1, d, r);
    vectors++;
    if (d !== exp_status()) begin miscompares++; $display("FAIL ovr_clear: got %h want %h", d, exp_status()); end
  endtask

  task automatic test_glitch_frame();
    logic [15:0] d, e; logic r;
    @(negedge clk); rx = 1'b0;
    repeat (4) @(negedge clk); rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    apb_read(2'd1, d, r);
    vectors++;
    if (d !== exp_status()) begin miscompares++; $display("FAIL glitch_status: got %h want %h", d, exp_status()); end
    send_frame(8'h3C, 1'b0); model_frame(8'h3C, 1'b0);
    apb_read(2'd1, d, r);
    vectors++;
    if (d !== exp_status() || d !== 16'h0008) begin miscompares++; $display("FAIL frame_status: got %h want %h", d, exp_status()); end
    send_frame(8'h7E, 1'b1); model_frame(8'h7E, 1'b1);
    e = exp_data_pop();
    apb_read(2'd0, d, r);
    vectors++;
    if (d !== e || e !== 16'h007E) begin miscompares++; $display("FAIL after_break_data: got %h want %h", d, e); end
    apb_write(2'd1, 16'h0008); m_frame = 1'b0;
    apb_read(2'd1, d, r);
    vectors++;
    if (d !== exp_status()) begin miscompares++; $display("FAIL frame_clear: got %h want %h", d, exp_status()); end
  endtask

  task automatic test_full_pushpop();
    logic [15:0] d, e; logic r; logic [7:0] b;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom); send_frame(b, 1'b1); model_frame(b, 1'b1);
    end
    b = 8'($urandom);
    fork
      send_frame(b, 1'b1);
      begin
        @(negedge clk);
        repeat (PUSH_EDGE - 2) @(negedge clk);
        apb_read(2'd0, d, r);
      end
    join
    e = exp_data_pop(); q.push_back(b);
    vectors++;
    if (d !== e) begin miscompares++; $display("FAIL pushpop_data: got %h want %h", d, e); end
    apb_read(2'd1, d, r);
    vectors++;
    if (d !== exp_status() || d !== 16'h0803) begin miscompares++; $display("FAIL pushpop_status: got %h want %h", d, exp_status()); end
    for (int i = 0; i < DEPTH; i++) begin
      e = exp_data_pop();
      apb_read(2'd0, d, r);
      vectors++;
      if (d !== e) begin miscompares++; $display("FAIL pushpop_drain%0d: got %h want %h", i, d, e); end
    end
  endtask

  task automatic test_enable();
    logic [15:0] d, e; logic r;
    fork
      send_frame(8'($urandom), 1'b1);
      begin repeat (70) @(negedge clk); apb_write(2'd2, 16'h0000); end
    join
    apb_read(2'd2, d, r);
    vectors++;
    if (d !== 16'h0000) begin miscompares++; $display("FAIL disable_ctrl: got %h want 0000", d); end
    apb_read(2'd1, d, r);
    vectors++;
    if (d !== exp_status()) begin miscompares++; $display("FAIL disable_status: got %h want %h", d, exp_status()); end
    apb_write(2'd2, 16'h0001);
    send_frame(8'h55, 1'b1); model_frame(8'h55, 1'b1);
    e = exp_data_pop();
    apb_read(2'd0, d, r);
    vectors++;
    if (d !== e || e !== 16'h0055) begin miscompares++; $display("FAIL reenable_data: got %h want %h", d, e); end
  endtask

  task automatic test_irq_reset();
    logic [15:0] d; logic r; logic [7:0] b;
    apb_write(2'd2, 16'h0003);
    b = 8'($urandom); send_frame(b, 1'b1); model_frame(b, 1'b1);
    @(negedge clk); #1;
    vectors++;
    if (rx_irq !== 1'b1) begin miscompares++; $display("FAIL irq_high: got %b want 1", rx_irq); end
    fork
      send_frame(8'($urandom), 1'b1);
      begin
        repeat (60) @(negedge clk);
        #2; reset = 1'b0; paddr = 16'h1; pwrite = 1'b0; psel = 1'b1; penable = 1'b1;
        #1;
        vectors++;
        if (rx_irq !== 1'b0 || prdata !== 16'h0000 || pready !== 1'b0) begin
          miscompares++;
          $display("FAIL async_reset: got irq=%b prdata=%h pready=%b want 0/0000/0", rx_irq, prdata, pready);
        end
        #1; psel = 1'b0; penable = 1'b0;
      end
    join
    @(negedge clk); reset = 1'b1;
    model_reset();
    apb_read(2'd1, d, r);
    vectors++;
    if (d !== exp_status()) begin miscompares++; $display("FAIL post_reset_status: got %h want %h", d, exp_status()); end
    apb_read(2'd2, d, r);
    vectors++;
    if (d !== 16'h0001) begin miscompares++; $display("FAIL post_reset_ctrl: got %h want 0001", d); end
  endtask

  task automatic test_random();
    logic [15:0] d, e; logic r; logic [7:0] b; logic stop_b;
    for (int it = 0; it < 14; it++) begin
      b = 8'($urandom);
      stop_b = ($urandom_range(0, 5) != 0);
      send_frame(b, stop_b); model_frame(b, stop_b);
      apb_read(2'd1, d, r);
      vectors++;
      if (d !== exp_status()) begin miscompares++; $display("FAIL rand_status%0d: got %h want %h", it, d, exp_status()); end
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        e = exp_data_pop();
        apb_read(2'd0, d, r);
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL rand_data%0d: got %h want %h", it, d, e); end
      end
      if (m_frame || m_ovr) begin
        apb_write(2'd1, 16'h001C); m_frame = 1'b0; m_ovr = 1'b0; m_par = 1'b0;
      end
    end
  endtask

`ifdef VMICRO16_UART_RX_PARITY_EN
  task automatic test_parity();
    logic [15:0] d, e; logic r;
    par_flip = 1'b1;
    send_frame(8'h03, 1'b1); model_frame(8'h03, 1'b1);
    par_flip = 1'b0;
    apb_read(2'd1, d, r);
    vectors++;
    if (d !== exp_status() || d[4] !== 1'b1) begin miscompares++; $display("FAIL parity_status: got %h want %h", d, exp_status()); end
    send_frame(8'h03, 1'b1); model_frame(8'h03, 1'b1);
    e = exp_data_pop();
    apb_read(2'd0, d, r);
    vectors++;
    if (d !== e || e !== 16'h0003) begin miscompares++; $display("FAIL parity_data: got %h want %h", d, e); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_a5();
    test_overrun();
    test_glitch_frame();
    test_full_pushpop();
    test_enable();
    test_irq_reset();
    test_random();
`ifdef VMICRO16_UART_RX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
